// File: rtl/lcd_sched_pkg.sv
// Shared types and index arithmetic for the frame-synchronous LCD image scheduler.
package lcd_sched_pkg;

  typedef enum logic [1:0] {IDLE, PEND, SWITCH} state_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_NEXT, DIR_PREV} dir_t;

  // Step an image index one place forward or backward, wrapping within 0..n_img-1.
  function automatic int wrap_step(input int cur, input logic dec, input int n_img);
    if (dec) return (cur == 0) ? n_img - 1 : cur - 1;
    return (cur == n_img - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/lcd_edge_det.sv
// Single-bit edge detector: registered history plus combinational rise or fall strobe.
module lcd_edge_det #(
  parameter bit RST_VAL = 1'b0,
  parameter bit FALL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic hist_p1;

  always_ff @(posedge clk) begin
    if (rst) hist_p1 <= RST_VAL;
    else     hist_p1 <= d;
  end

  assign pulse = FALL ? (hist_p1 & ~d) : (~hist_p1 & d);

endmodule

// File: rtl/lcd_image_scheduler.sv
// Chooses the image index for the LCD datapath; manual and auto-advance requests
// are committed only on the edge that ends a frame-start (VD falling) cycle.
module lcd_image_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int N_IMG          = 4,
  parameter int SEL_W          = 2,
  parameter int FRAMES_PER_IMG = 60,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VD,
  input  logic             NEXT,
  input  logic             PREV,
  input  logic             AUTO_EN,
  output logic [SEL_W-1:0] IMG_SEL,
  output logic             SWITCH_PULSE,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             BUSY
);

  logic fs, next_rise, prev_rise;
  logic man_edge, auto_req, go_switch;
  dir_t man_dir, sw_dir;
  dir_t pending, pending_d;
  state_t state, state_d;
  logic [SEL_W-1:0] img_sel, img_sel_d;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_d;
  logic switch_pulse;

  lcd_edge_det #(.RST_VAL(1'b1), .FALL(1'b1)) u_vd_det (
    .clk(CLK), .rst(RST), .d(VD), .pulse(fs)
  );

  lcd_edge_det #(.RST_VAL(1'b0), .FALL(1'b0)) u_next_det (
    .clk(CLK), .rst(RST), .d(NEXT), .pulse(next_rise)
  );

  lcd_edge_det #(.RST_VAL(1'b0), .FALL(1'b0)) u_prev_det (
    .clk(CLK), .rst(RST), .d(PREV), .pulse(prev_rise)
  );

  always_comb begin
    man_edge    = next_rise ^ prev_rise;
    man_dir     = next_rise ? DIR_NEXT : DIR_PREV;
    auto_req    = fs && AUTO_EN && (frame_cnt == CNT_W'(FRAMES_PER_IMG - 1));
    state_d     = state;
    pending_d   = man_edge ? man_dir : pending;
    go_switch   = 1'b0;
    sw_dir      = DIR_NEXT;
    case (state)
      IDLE: begin
        if (auto_req) begin
          go_switch = 1'b1;
          state_d   = SWITCH;
          // An edge seen in the frame-start cycle waits for the next frame.
          pending_d = man_edge ? man_dir : DIR_NONE;
        end else if (man_edge) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (fs) begin
          // Manual request wins; a coincident auto request is simply dropped.
          go_switch = 1'b1;
          sw_dir    = pending;
          state_d   = SWITCH;
          pending_d = man_edge ? man_dir : DIR_NONE;
        end
      end
      SWITCH: state_d = (pending_d != DIR_NONE) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase

    img_sel_d = go_switch
      ? SEL_W'(wrap_step(int'(img_sel), sw_dir == DIR_PREV, N_IMG))
      : img_sel;

    if (!AUTO_EN || go_switch) frame_cnt_d = '0;
    else if (fs)               frame_cnt_d = frame_cnt + CNT_W'(1);
    else                       frame_cnt_d = frame_cnt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      pending      <= DIR_NONE;
      img_sel      <= '0;
      frame_cnt    <= '0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      pending      <= pending_d;
      img_sel      <= img_sel_d;
      frame_cnt    <= frame_cnt_d;
      switch_pulse <= go_switch;
    end
  end

  assign IMG_SEL      = img_sel;
  assign SWITCH_PULSE = switch_pulse;
  assign FRAME_CNT    = frame_cnt;
  assign BUSY         = (state != IDLE);

endmodule
